// File: rtl/pll_ctrl_pkg.sv
// Shared types and default constants for the PLL lock/reset controller.
// The enum order matches the nominal bring-up path.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        LOCKED    = 3'd3,
        SETTLE    = 3'd4
    } state_t;

    localparam int unsigned DEF_RESET_CYCLES  = 16;
    localparam int unsigned DEF_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_LOCK_TIMEOUT  = 65536;
    localparam int unsigned DEF_SETTLE_CYCLES = 64;
    localparam logic [3:0]  DEF_PSDA_INIT     = 4'b0000;
    localparam logic [3:0]  DEF_DUTYDA_INIT   = 4'b1000;

    localparam logic [7:0]  RETRY_MAX         = 8'hFF;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for signals arriving asynchronously to clk.
// Both flops clear on rst so the consumer sees a known 0 after reset.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_ctrl.sv
// PLL bring-up controller: pulses PLL reset, qualifies LOCK, applies phase/duty
// updates with a settle window, and retries on timeout or loss of lock.
module pll_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter logic [3:0]  PSDA_INIT     = DEF_PSDA_INIT,
    parameter logic [3:0]  DUTYDA_INIT   = DEF_DUTYDA_INIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    output logic       pll_rst,
    output logic [3:0] pll_psda,
    output logic [3:0] pll_dutyda,
    input  logic       cfg_valid,
    input  logic [3:0] cfg_psda,
    input  logic [3:0] cfg_dutyda,
    output logic       cfg_ready,
    output logic       locked,
    output logic       lock_lost,
    output logic [7:0] retry_cnt
);

    localparam int unsigned RW = cnt_width(RESET_CYCLES);
    localparam int unsigned BW = cnt_width(STABLE_CYCLES);
    localparam int unsigned TW = cnt_width(LOCK_TIMEOUT);
    localparam int unsigned SW = cnt_width(SETTLE_CYCLES);

    localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);
    localparam logic [BW-1:0] STB_LAST = BW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == RETRY_MAX) ? v : v + 8'd1;
    endfunction

    state_t        state;
    state_t        state_nxt;
    logic          lk;
    logic [RW-1:0] rst_cnt;
    logic [BW-1:0] stable_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [SW-1:0] settle_cnt;
    logic          lost_nxt;
    logic          bump_nxt;
    logic          load_nxt;
    logic          acq_now;
    logic          acq_nxt;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lk)
    );

    // The cycle in WAIT_LOCK that first sees lk=1 counts toward the stable run,
    // so STABLE only needs STABLE_CYCLES-1 further good cycles.
    always_comb begin
        state_nxt = state;
        lost_nxt  = 1'b0;
        bump_nxt  = 1'b0;
        load_nxt  = 1'b0;
        case (state)
            RST_PLL: begin
                if (rst_cnt == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (tmo_cnt == TMO_LAST) begin
                    state_nxt = RST_PLL;
                    bump_nxt  = 1'b1;
                end else if (lk) begin
                    state_nxt = (STABLE_CYCLES <= 1) ? LOCKED : STABLE;
                end
            end
            STABLE: begin
                if (tmo_cnt == TMO_LAST) begin
                    state_nxt = RST_PLL;
                    bump_nxt  = 1'b1;
                end else if (!lk) begin
                    state_nxt = WAIT_LOCK;
                end else if (stable_cnt == STB_LAST) begin
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                // A lock drop wins over a simultaneous update request.
                if (!lk) begin
                    state_nxt = RST_PLL;
                    lost_nxt  = 1'b1;
                    bump_nxt  = 1'b1;
                end else if (cfg_valid) begin
                    state_nxt = SETTLE;
                    load_nxt  = 1'b1;
                end
            end
            SETTLE: begin
                if (settle_cnt == SET_LAST) begin
                    if (lk) begin
                        state_nxt = LOCKED;
                    end else begin
                        state_nxt = RST_PLL;
                        lost_nxt  = 1'b1;
                        bump_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = RST_PLL;
            end
        endcase
    end

    assign acq_now = (state == WAIT_LOCK) || (state == STABLE);
    assign acq_nxt = (state_nxt == WAIT_LOCK) || (state_nxt == STABLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RST_PLL;
            rst_cnt    <= '0;
            stable_cnt <= '0;
            tmo_cnt    <= '0;
            settle_cnt <= '0;
            pll_rst    <= 1'b1;
            locked     <= 1'b0;
            cfg_ready  <= 1'b0;
            lock_lost  <= 1'b0;
            retry_cnt  <= 8'd0;
            pll_psda   <= PSDA_INIT;
            pll_dutyda <= DUTYDA_INIT;
        end else begin
            state     <= state_nxt;
            pll_rst   <= (state_nxt == RST_PLL);
            locked    <= (state_nxt == LOCKED);
            cfg_ready <= (state_nxt == LOCKED);
            lock_lost <= lost_nxt;

            if (bump_nxt) begin
                retry_cnt <= sat_inc(retry_cnt);
            end

            if (load_nxt) begin
                pll_psda   <= cfg_psda;
                pll_dutyda <= cfg_dutyda;
            end

            rst_cnt    <= (state == RST_PLL && state_nxt == RST_PLL) ? rst_cnt + RW'(1) : '0;
            settle_cnt <= (state == SETTLE && state_nxt == SETTLE) ? settle_cnt + SW'(1) : '0;
            tmo_cnt    <= (acq_now && acq_nxt) ? tmo_cnt + TW'(1) : '0;

            if (state_nxt == STABLE) begin
                stable_cnt <= (state == STABLE) ? stable_cnt + BW'(1) : BW'(1);
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pll_ctrl.sv
// Scoreboard bench for pll_ctrl: a mode/run-length reference model predicts
// every cycle's registered outputs; a monitor compares them after each edge.
module tb_pll_ctrl;

    localparam int RC  = 4;
    localparam int SC  = 8;
    localparam int LT  = 32;
    localparam int STC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic       pll_rst;
    logic [3:0] pll_psda;
    logic [3:0] pll_dutyda;
    logic       cfg_valid;
    logic [3:0] cfg_psda;
    logic [3:0] cfg_dutyda;
    logic       cfg_ready;
    logic       locked;
    logic       lock_lost;
    logic [7:0] retry_cnt;

    pll_ctrl #(
        .RESET_CYCLES  (RC),
        .STABLE_CYCLES (SC),
        .LOCK_TIMEOUT  (LT),
        .SETTLE_CYCLES (STC),
        .PSDA_INIT     (4'b0000),
        .DUTYDA_INIT   (4'b1000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_lock   (pll_lock),
        .pll_rst    (pll_rst),
        .pll_psda   (pll_psda),
        .pll_dutyda (pll_dutyda),
        .cfg_valid  (cfg_valid),
        .cfg_psda   (cfg_psda),
        .cfg_dutyda (cfg_dutyda),
        .cfg_ready  (cfg_ready),
        .locked     (locked),
        .lock_lost  (lock_lost),
        .retry_cnt  (retry_cnt)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic       prst;
        logic       lck;
        logic       rdy;
        logic       lost;
        logic [7:0] retry;
        logic [3:0] psda;
        logic [3:0] duty;
    } resp_t;

    typedef enum int {M_RESET, M_ACQ, M_LOCKED, M_SETTLE} mode_e;

    resp_t exp_q[$];
    int    checks = 0;
    int    passed = 0;
    int    cyc    = 0;

    // Reference model: "acquire" covers the whole search for lock; run is the
    // number of consecutive good lock samples, age the cycles spent in a mode.
    mode_e      mode    = M_RESET;
    int         age     = 0;
    int         run     = 0;
    int         retries = 0;
    logic [3:0] m_psda  = 4'h0;
    logic [3:0] m_duty  = 4'h8;
    logic       m_lost  = 1'b0;
    logic [1:0] lk_pipe = 2'b00;

    function automatic void retry_up();
        if (retries < 255) retries++;
    endfunction

    function automatic resp_t model_step(input logic r, input logic pl, input logic v,
                                         input logic [3:0] ps, input logic [3:0] du);
        logic  lk;
        resp_t e;
        m_lost = 1'b0;
        if (r) begin
            mode = M_RESET; age = 0; run = 0; retries = 0;
            m_psda = 4'h0; m_duty = 4'h8; lk_pipe = 2'b00;
        end else begin
            lk      = lk_pipe[1];
            lk_pipe = {lk_pipe[0], pl};
            case (mode)
                M_RESET: begin
                    age++;
                    if (age == RC) begin mode = M_ACQ; age = 0; run = 0; end
                end
                M_ACQ: begin
                    if (age + 1 == LT) begin
                        retry_up(); mode = M_RESET; age = 0;
                    end else begin
                        age++;
                        run = lk ? run + 1 : 0;
                        if (run == SC) begin mode = M_LOCKED; age = 0; end
                    end
                end
                M_LOCKED: begin
                    if (!lk) begin
                        m_lost = 1'b1; retry_up(); mode = M_RESET; age = 0;
                    end else if (v) begin
                        m_psda = ps; m_duty = du; mode = M_SETTLE; age = 0;
                    end
                end
                M_SETTLE: begin
                    age++;
                    if (age == STC) begin
                        if (lk) begin
                            mode = M_LOCKED;
                        end else begin
                            m_lost = 1'b1; retry_up(); mode = M_RESET;
                        end
                        age = 0;
                    end
                end
                default: mode = M_RESET;
            endcase
        end
        e.prst  = (mode == M_RESET);
        e.lck   = (mode == M_LOCKED);
        e.rdy   = (mode == M_LOCKED);
        e.lost  = m_lost;
        e.retry = 8'(retries);
        e.psda  = m_psda;
        e.duty  = m_duty;
        return e;
    endfunction

    task automatic drive(input logic r, input logic pl, input logic v,
                         input logic [3:0] ps, input logic [3:0] du);
        @(negedge clk);
        rst        = r;
        pll_lock   = pl;
        cfg_valid  = v;
        cfg_psda   = ps;
        cfg_dutyda = du;
        exp_q.push_back(model_step(r, pl, v, ps, du));
    endtask

    task automatic idle(input logic pl, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, pl, 1'b0, 4'($urandom()), 4'($urandom()));
    endtask

    task automatic until_mode(input mode_e m, input logic pl, input int limit);
        for (int i = 0; i < limit && mode != m; i++) idle(pl, 1);
    endtask

    // Monitor: every edge that has a prediction queued gets one full comparison.
    initial begin
        resp_t e;
        resp_t a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {pll_rst, locked, cfg_ready, lock_lost, retry_cnt, pll_psda, pll_dutyda};
                checks++;
                if (a === e) begin
                    passed++;
                end else begin
                    $display("FAIL outputs cyc=%0d got rst=%b lck=%b rdy=%b lost=%b retry=%0d psda=%h duty=%h want rst=%b lck=%b rdy=%b lost=%b retry=%0d psda=%h duty=%h",
                             cyc, a.prst, a.lck, a.rdy, a.lost, a.retry, a.psda, a.duty,
                             e.prst, e.lck, e.rdy, e.lost, e.retry, e.psda, e.duty);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; pll_lock = 1'b0; cfg_valid = 1'b0; cfg_psda = 4'h0; cfg_dutyda = 4'h0;

        // Reset, then start-up with lock arriving 10 cycles after release.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        idle(1'b0, 10);
        idle(1'b1, 20);

        // Successful phase/duty update.
        until_mode(M_LOCKED, 1'b1, 60);
        drive(1'b0, 1'b1, 1'b1, 4'h3, 4'h6);
        idle(1'b1, 10);

        // Failed settle: lock gone by the end of the settle window.
        drive(1'b0, 1'b1, 1'b1, 4'($urandom()), 4'($urandom()));
        idle(1'b0, 8);
        idle(1'b1, 2);
        until_mode(M_LOCKED, 1'b1, 80);

        // Loss of lock while locked.
        idle(1'b0, 1);
        idle(1'b1, 4);

        // One-cycle glitch part way through the stable run.
        until_mode(M_ACQ, 1'b1, 40);
        for (int i = 0; i < 40 && run != 3; i++) idle(1'b1, 1);
        idle(1'b0, 1);
        until_mode(M_LOCKED, 1'b1, 80);
        idle(1'b1, 2);

        // Lock drop coinciding with an update request.
        idle(1'b0, 1);
        idle(1'b1, 1);
        drive(1'b0, 1'b1, 1'b1, 4'hA, 4'h5);
        until_mode(M_LOCKED, 1'b1, 80);

        // Reset asserted in the middle of a settle window.
        drive(1'b0, 1'b1, 1'b1, 4'hC, 4'h2);
        idle(1'b1, 2);
        drive(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
        until_mode(M_LOCKED, 1'b1, 80);

        // Randomized traffic with rare lock dropouts and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 499) == 0),
                  ($urandom_range(0, 99) < 97),
                  ($urandom_range(0, 9) == 0),
                  4'($urandom()), 4'($urandom()));
        end

        // Lock never arrives: repeated timeouts, long enough to saturate retries.
        idle(1'b0, (RC + LT) * 260);

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain pending=%0d want 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
